// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data memory responder.
// Provides size encodings, the FSM state enum and the byte-enable function.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dmem_state_t;

    // Byte lanes touched by an access; size 3 behaves as a word.
    function automatic logic [3:0] byte_en(input logic [1:0] size,
                                           input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        unique case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: picks the addressed byte/half out of a memory word and
// sign- or zero-extends it. Ports: word, offset, size, uns -> result.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] result
);

    logic [31:0] shifted;

    assign shifted = word >> {offset, 3'b000};

    always_comb begin
        result = shifted;
        unique case (size)
            SZ_BYTE: result = uns ? {24'b0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: result = uns ? {16'b0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: word-organised data memory behind a valid/ready
// request/response handshake with a configurable access latency.
// Ports: clk, reset (async, active-high); request req_valid/req_ready/
// req_we/req_addr/req_wdata/req_size/req_unsigned; response rsp_valid/
// rsp_ready/rsp_rdata/rsp_err.
// Optional: define DMEM_MISALIGN_CHECK_EN to flag misaligned half/word
// accesses as errors instead of forcing them to natural alignment.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    dmem_state_t state, state_nx;

    logic [3:0]  cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          do_access;
    logic          is_half;
    logic          is_word;
    logic          oor;
    logic          mis;
    logic          err;
    logic [1:0]    off;
    logic [3:0]    be;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic [31:0]   ld_data;
    logic [31:0]   wshift;

    assign accept    = req_valid && (state == ST_IDLE);
    assign do_access = (state == ST_ACCESS) && (cnt == 4'd0);

    assign is_half = (r_size == SZ_HALF);
    assign is_word = (r_size == SZ_WORD) || (r_size == 2'd3);
    assign oor     = {2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS);
    assign mis     = (is_half && r_addr[0]) || (is_word && (r_addr[1:0] != 2'b00));
    assign idx     = r_addr[AW+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign err = oor || mis;
    assign off = r_addr[1:0];
`else
    // Misaligned half/word accesses drop the low address bits.
    assign err = oor;
    assign off = is_word ? 2'b00
               : is_half ? {r_addr[1], 1'b0}
               : r_addr[1:0];
`endif

    assign be      = byte_en(r_size, off);
    assign wshift  = r_wdata << {off, 3'b000};
    assign rd_word = oor ? 32'd0 : mem[idx];

    dmem_load_align u_align (
        .word   (rd_word),
        .offset (off),
        .size   (r_size),
        .uns    (r_uns),
        .result (ld_data)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // FSM next state.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:   if (req_valid) state_nx = ST_ACCESS;
            ST_ACCESS: if (cnt == 4'd0) state_nx = ST_RESP;
            ST_RESP:   if (rsp_ready) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        req_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

    // Request capture, latency counter and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_size  <= SZ_BYTE;
            r_uns   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                cnt     <= LAT_M1;
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_size  <= req_size;
                r_uns   <= req_unsigned;
            end else if (state == ST_ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                rdata_q <= (r_we || err) ? 32'd0 : ld_data;
                err_q   <= err;
            end else if (state == ST_RESP && rsp_ready) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b0;
            end
        end
    end

    // Storage is not reset; reset forces IDLE so no store can commit.
    always_ff @(posedge clk) begin
        if (do_access && r_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wshift[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed self-checking bench for
// data_memory_responder (LATENCY=1 and LATENCY=4 instances).
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        reset_a, reset_b;
    logic        req_valid_a, req_valid_b;
    logic        req_ready_a, req_ready_b;
    logic        req_we;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid_a, rsp_valid_b;
    logic        rsp_ready_a, rsp_ready_b;
    logic [31:0] rsp_rdata_a, rsp_rdata_b;
    logic        rsp_err_a, rsp_err_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_a (
        .clk(clk), .reset(reset_a),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
        .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
    );

    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut_b (
        .clk(clk), .reset(reset_b),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
        .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input bit b, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size,
                        input logic uns);
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        if (b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        chk("req_ready_idle", {31'd0, b ? req_ready_b : req_ready_a}, 32'd1);
        @(posedge clk); #1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
    endtask

    // Cycles counted from the accept cycle to the first rsp_valid cycle.
    task automatic wait_rsp(input bit b, output int lat);
        lat = 1;
        while (!(b ? rsp_valid_b : rsp_valid_a) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("rsp_valid_seen", {31'd0, b ? rsp_valid_b : rsp_valid_a}, 32'd1);
    endtask

    task automatic take(input bit b);
        if (b) rsp_ready_b = 1'b1; else rsp_ready_a = 1'b1;
        @(posedge clk); #1;
        rsp_ready_a = 1'b0; rsp_ready_b = 1'b0;
    endtask

    task automatic xact(input string tag, input bit b, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat);
        int lat;
        send(b, we, addr, wdata, size, uns);
        wait_rsp(b, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, b ? rsp_rdata_b : rsp_rdata_a, exp_rdata);
        chk({tag, "_err"}, {31'd0, b ? rsp_err_b : rsp_err_a}, {31'd0, exp_err});
        take(b);
    endtask

    initial begin
        logic [31:0] held;
        int lat;
        reset_a = 1'b1; reset_b = 1'b1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        rsp_ready_a = 1'b0; rsp_ready_b = 1'b0;
        req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'd0; req_unsigned = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_a = 1'b0; reset_b = 1'b0;
        #1;
        chk("rst_req_ready", {31'd0, req_ready_a}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_a, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err_a}, 32'd0);

        // Word store/load and latency.
        xact("st_w10", 0, 1, 32'h10, 32'hDEADBEEF, 2'd2, 0, 32'h0, 0, 2);
        xact("ld_w10", 0, 0, 32'h10, 32'h0, 2'd2, 0, 32'hDEADBEEF, 0, 2);

        // Byte store merge and sub-word loads.
        xact("st_b13", 0, 1, 32'h13, 32'h00000055, 2'd0, 0, 32'h0, 0, 2);
        xact("ld_w10b", 0, 0, 32'h10, 32'h0, 2'd2, 0, 32'h55ADBEEF, 0, 2);
        xact("ld_b11s", 0, 0, 32'h11, 32'h0, 2'd0, 0, 32'hFFFFFFBE, 0, 2);
        xact("ld_b11u", 0, 0, 32'h11, 32'h0, 2'd0, 1, 32'h000000BE, 0, 2);
        xact("ld_h12s", 0, 0, 32'h12, 32'h0, 2'd1, 0, 32'h000055AD, 0, 2);
        xact("ld_h10s", 0, 0, 32'h10, 32'h0, 2'd1, 0, 32'hFFFFBEEF, 0, 2);
        xact("ld_h10u", 0, 0, 32'h10, 32'h0, 2'd1, 1, 32'h0000BEEF, 0, 2);
        xact("ld_sz3", 0, 0, 32'h10, 32'h0, 2'd3, 0, 32'h55ADBEEF, 0, 2);

        // Range boundary.
        xact("st_w0", 0, 1, 32'h0, 32'h11223344, 2'd2, 0, 32'h0, 0, 2);
        xact("st_3fc", 0, 1, 32'h3FC, 32'hA5A5C3C3, 2'd2, 0, 32'h0, 0, 2);
        xact("ld_3fc", 0, 0, 32'h3FC, 32'h0, 2'd2, 0, 32'hA5A5C3C3, 0, 2);
        xact("ld_400", 0, 0, 32'h400, 32'h0, 2'd2, 0, 32'h0, 1, 2);
        xact("st_400", 0, 1, 32'h400, 32'hCAFEF00D, 2'd2, 0, 32'h0, 1, 2);
        xact("ld_w0", 0, 0, 32'h0, 32'h0, 2'd2, 0, 32'h11223344, 0, 2);

        // Response stall with an ignored second request.
        send(0, 0, 32'h10, 32'h0, 2'd2, 0);
        wait_rsp(0, lat);
        held = rsp_rdata_a;
        chk("stall_first", held, 32'h55ADBEEF);
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0;
        req_size = 2'd2; req_valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", {31'd0, rsp_valid_a}, 32'd1);
            chk("stall_rdata", rsp_rdata_a, held);
            chk("stall_ready", {31'd0, req_ready_a}, 32'd0);
        end
        req_valid_a = 1'b0;
        take(0);
        chk("after_take_valid", {31'd0, rsp_valid_a}, 32'd0);
        xact("ld_after", 0, 0, 32'h10, 32'h0, 2'd2, 0, 32'h55ADBEEF, 0, 2);

        // LATENCY=4: reset during ACCESS drops the store.
        xact("b_st20", 1, 1, 32'h20, 32'hAAAA5555, 2'd2, 0, 32'h0, 0, 5);
        send(1, 1, 32'h20, 32'h12345678, 2'd2, 0);
        @(posedge clk); #1;
        reset_b = 1'b1;
        #1;
        chk("b_rst_valid", {31'd0, rsp_valid_b}, 32'd0);
        chk("b_rst_err", {31'd0, rsp_err_b}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_b = 1'b0;
        #1;
        chk("b_rst_ready", {31'd0, req_ready_b}, 32'd1);
        chk("b_rst_valid2", {31'd0, rsp_valid_b}, 32'd0);
        xact("b_ld20", 1, 0, 32'h20, 32'h0, 2'd2, 0, 32'hAAAA5555, 0, 5);

        // Misaligned half/word.
`ifdef DMEM_MISALIGN_CHECK_EN
        xact("mis_h11", 0, 0, 32'h11, 32'h0, 2'd1, 0, 32'h0, 1, 2);
        xact("mis_w12", 0, 0, 32'h12, 32'h0, 2'd2, 0, 32'h0, 1, 2);
        xact("mis_st", 0, 1, 32'h12, 32'h0, 2'd2, 0, 32'h0, 1, 2);
        xact("mis_chk", 0, 0, 32'h10, 32'h0, 2'd2, 0, 32'h55ADBEEF, 0, 2);
`else
        xact("mis_h11", 0, 0, 32'h11, 32'h0, 2'd1, 0, 32'hFFFFBEEF, 0, 2);
        xact("mis_w12", 0, 0, 32'h12, 32'h0, 2'd2, 0, 32'h55ADBEEF, 0, 2);
        xact("mis_sth", 0, 1, 32'h13, 32'h00007788, 2'd1, 0, 32'h0, 0, 2);
        xact("mis_chk", 0, 0, 32'h10, 32'h0, 2'd2, 0, 32'h7788BEEF, 0, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 1, range 1..15, cycles spent in ACCESS before a response.
REQ-003 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit, the CPU presents a load/store request.
REQ-006 SHALL have port req_ready, output, 1 bit, the responder accepts a request this cycle.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32 bits, byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits, store data, right-aligned.
REQ-010 SHALL have port req_size, input, 2 bits: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
REQ-011 SHALL have port req_unsigned, input, 1 bit, zero-extend the load (LBU/LHU).
REQ-012 SHALL have port rsp_valid, output, 1 bit, a response is pending.
REQ-013 SHALL have port rsp_ready, input, 1 bit, the CPU accepts the response.
REQ-014 SHALL have port rsp_rdata, output, 32 bits, extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err, output, 1 bit, the access was out of range or misaligned.

Function
REQ-016 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-017 SHALL drive req_ready = 1 only in IDLE; a request is accepted on a cycle with req_valid & req_ready.
REQ-018 SHALL, on acceptance, register we/addr/wdata/size/unsigned, load latency counter with LATENCY-1, and enter ACCESS.
REQ-019 SHALL in ACCESS decrement the counter each cycle; at 0, perform the access and enter RESP on the next edge. Accept-to-rsp_valid latency = LATENCY+1 cycles.
REQ-020 SHALL commit a store only on the ACCESS->RESP edge, byte-masked by size and addr[1:0]; unaddressed bytes are unchanged.
REQ-021 SHALL extract the load byte/half from the word at addr[1:0] and sign-extend it unless req_unsigned.
REQ-022 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready, then return to IDLE on that edge; there is no same-cycle re-accept.
REQ-023 SHALL treat word index addr[31:2] >= DEPTH_WORDS as out of range: rsp_err = 1, no write, rsp_rdata = 0.
REQ-024 SHALL ignore req_valid outside IDLE; inputs may change freely then.
REQ-025 SHALL leave memory contents uninitialised and not reset.

Reset
REQ-026 SHALL, on reset assertion, immediately force IDLE, req_ready = 1 once reset releases, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, and counter = 0.
REQ-027 SHALL, on reset during ACCESS, discard the pending store; during RESP, drop the response.

Configuration
REQ-028 SHALL, with DMEM_MISALIGN_CHECK_EN defined, flag half accesses with addr[0] = 1 and word accesses with addr[1:0] != 0 as rsp_err = 1, with no write and rsp_rdata = 0.
REQ-029 SHALL, without DMEM_MISALIGN_CHECK_EN, force misaligned half/word accesses to natural alignment by masking the low address bits, with rsp_err driven only by range.

Structure
REQ-030 SHALL take from shared package dmem_pkg: the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum, and the byte-enable function.
REQ-031 SHALL place load extraction/extension in sub-module dmem_load_align (combinational: word, offset, size, unsigned -> 32-bit result).

Verification
REQ-032 SHALL verify: store word 0xDEADBEEF @0x10, then load word @0x10 -> rdata 0xDEADBEEF, err 0, rsp_valid 2 cycles after accept (LATENCY=1).
REQ-033 SHALL verify: after REQ-032, store byte 0x55 @0x13, then load word @0x10 -> 0x55ADBEEF; then load byte @0x11 signed -> 0xFFFFFFBE and unsigned -> 0x000000BE.
REQ-034 SHALL verify: load @0x400 (DEPTH 256) -> err 1, rdata 0; a store there leaves word 0 unchanged.
REQ-035 SHALL verify: rsp_ready held low 5 cycles -> rsp_valid/rdata stable and req_ready 0 throughout; a second req_valid is ignored.
REQ-036 SHALL verify: LATENCY=4, store accepted then reset asserted in ACCESS -> a later load of the same address shows the old data and rsp_valid is 0 immediately after reset.
REQ-037 SHALL verify: with the macro, load half @0x11 -> err 1; without the macro -> data from @0x10, err 0.
